// File: rtl/hit_uart_tx_pkg.sv
// Shared constants for the hit UART transmitter: state encoding,
// default baud divisor and frame length.
package hit_uart_tx_pkg;

    // 3-bit state codes, shared by the FIFO-read FSM and the serializer
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_LATCH = ST_LATCH,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } state_e;

    // 100 MHz / 115200 baud
    localparam int DEF_CLKS_PER_BIT = 868;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/hit_uart_tx_core.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// A load pulse in IDLE captures the byte; done pulses on the last
// cycle of the stop bit.
module uart_tx_core
    import hit_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic bit_end;
    assign bit_end = (cnt_q == 16'd0);

    // Serializer state, divider, bit index, shift register and line driver
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state: the divider reloads at every bit boundary so the bit
    // period is exactly CLKS_PER_BIT cycles; tx_d is the level of the
    // bit that begins at the coming edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (load_i) begin
                    state_d = S_START;
                    shift_d = data_i;
                    cnt_d   = RELOAD;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = RELOAD;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/hit_uart_tx.sv
// Hit-FIFO to UART bridge: pops one byte from the hit FIFO, hands it to
// the serializer and counts completed frames.
module hit_uart_tx
    import hit_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        enable,
    input  logic        fifo_data_available,
    input  logic [7:0]  fifo_dout,
    output logic        read_fifo,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    // S_START here stands for "serializer running" (START/DATA/STOP
    // are sequenced inside the core).
    state_e      state_q, state_d;
    logic [15:0] words_q, words_d;
    logic        core_load;
    logic        core_done;

    // FSM state and frame counter
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            words_q <= 16'd0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
        end
    end

    // Next-state: a read is only started from IDLE, so enable or
    // fifo_data_available changing mid-frame never disturbs the frame.
    always_comb begin
        state_d = state_q;
        words_d = words_q;
        case (state_q)
            S_IDLE:  if (enable && fifo_data_available) state_d = S_READ;
            S_READ:  state_d = S_LATCH;
            S_LATCH: state_d = S_START;
            S_START: begin
                if (core_done) begin
                    state_d = S_IDLE;
                    words_d = words_q + 16'd1;   // wraps at 0xFFFF
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // fifo_dout is valid in LATCH, one cycle after the read strobe
    assign core_load  = (state_q == S_LATCH);
    assign read_fifo  = (state_q == S_READ);
    assign busy       = (state_q != S_IDLE);
    assign words_sent = words_q;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk_i  (SYSCLK),
        .rst_i  (RESET),
        .load_i (core_load),
        .data_i (fifo_dout),
        .tx_o   (tx),
        .done_o (core_done)
    );

endmodule

// File: tb/tb_hit_uart_tx.sv
// Directed bench for hit_uart_tx with CLKS_PER_BIT=4 and a small FIFO model.
module tb_hit_uart_tx;

    logic        SYSCLK;
    logic        RESET;
    logic        enable;
    logic        fifo_data_available;
    logic [7:0]  fifo_dout;
    logic        read_fifo;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    int total = 0;
    int bad   = 0;

    hit_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .SYSCLK              (SYSCLK),
        .RESET               (RESET),
        .enable              (enable),
        .fifo_data_available (fifo_data_available),
        .fifo_dout           (fifo_dout),
        .read_fifo           (read_fifo),
        .tx                  (tx),
        .busy                (busy),
        .words_sent          (words_sent)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // FIFO model: read data valid one cycle after the strobe
    logic [7:0] mem [0:15];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  cyc    = 0;
    int  rd_cnt = 0;
    bit  underflow = 1'b0;

    assign fifo_data_available = (wr_ptr != rd_ptr);

    initial fifo_dout = 8'h00;

    always @(posedge SYSCLK) begin
        cyc <= cyc + 1;
        if (read_fifo) begin
            if (rd_ptr == wr_ptr) underflow <= 1'b1;
            fifo_dout <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
            rd_cnt    <= rd_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // returns number of cycles until read_fifo seen, 0 if never within lim
    task automatic wait_read(input int lim, output int n);
        n = 0;
        for (int i = 1; i <= lim; i++) begin
            tick(1);
            if (read_fifo) begin
                n = i;
                break;
            end
        end
    endtask

    // called at the READ-cycle sample; returns at the last STOP sample
    task automatic recv(output logic [9:0] fr, output bit stable);
        logic [3:0] s;
        stable = 1'b1;
        fr = '0;
        tick(1);
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 4; k++) begin
                tick(1);
                s[k] = tx;
            end
            if (s != 4'b0000 && s != 4'b1111) stable = 1'b0;
            fr[b] = s[0];
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
    endtask

    initial begin
        logic [9:0] fr;
        bit st;
        int n, t1, t2, rc;
        bit quiet;

        RESET  = 1'b1;
        enable = 1'b0;
        tick(1);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_read", read_fifo, 0);
        chk("rst_words", words_sent, 0);
        RESET = 1'b0;

        // single word 0x3A
        enable = 1'b1;
        push(8'h3A);
        wait_read(10, n);
        chk("t1_read_lat", n, 1);
        chk("t1_busy_read", busy, 1);
        recv(fr, st);
        chk("t1_frame", fr, 10'b1_0011_1010_0);
        chk("t1_stable", st, 1);
        tick(1);
        chk("t1_busy_idle", busy, 0);
        chk("t1_words", words_sent, 1);
        chk("t1_tx_idle", tx, 1);
        tick(5);
        chk("t1_one_read", rd_cnt, 1);

        // back-to-back 0x07, 0x38
        do_reset();
        push(8'h07);
        push(8'h38);
        wait_read(10, n);
        t1 = cyc;
        recv(fr, st);
        chk("t2_frame0", fr, {1'b1, 8'h07, 1'b0});
        wait_read(10, n);
        t2 = cyc;
        chk("t2_gap", t2 - t1, 43);
        recv(fr, st);
        chk("t2_frame1", fr, {1'b1, 8'h38, 1'b0});
        tick(1);
        chk("t2_words", words_sent, 2);

        // enable gating
        do_reset();
        enable = 1'b0;
        push(8'h55);
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (read_fifo !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("t3_gated", quiet, 1);
        enable = 1'b1;
        wait_read(2, n);
        chk("t3_start", n != 0, 1);
        enable = 1'b0;          // drop enable mid-frame
        push(8'h66);
        recv(fr, st);
        chk("t3_frame", fr, {1'b1, 8'h55, 1'b0});
        rc = rd_cnt;
        tick(20);
        chk("t3_no_new_read", rd_cnt, rc);
        chk("t3_busy", busy, 0);
        enable = 1'b1;
        wait_read(5, n);
        recv(fr, st);
        chk("t3_frame2", fr, {1'b1, 8'h66, 1'b0});
        tick(1);

        // mid-frame reset
        do_reset();
        push(8'h3F);
        wait_read(10, n);
        tick(15);
        RESET = 1'b1;
        #1;
        chk("t4_tx", tx, 1);
        chk("t4_busy", busy, 0);
        chk("t4_words", words_sent, 0);
        push(8'h81);
        rc = rd_cnt;
        tick(20);
        chk("t4_no_read_in_rst", rd_cnt, rc);
        RESET = 1'b0;
        wait_read(10, n);
        chk("t4_first_read", n, 1);
        recv(fr, st);
        chk("t4_frame", fr, {1'b1, 8'h81, 1'b0});
        tick(1);
        chk("t4_words_after", words_sent, 1);

        // wrap 0xFFFF -> 0, upper bits transmitted unmasked
        do_reset();
        force dut.words_q = 16'hFFFF;
        tick(1);
        release dut.words_q;
        chk("t5_preload", words_sent, 16'hFFFF);
        push(8'hC5);
        wait_read(10, n);
        recv(fr, st);
        chk("t5_frame", fr, {1'b1, 8'hC5, 1'b0});
        tick(1);
        chk("t5_wrap", words_sent, 0);

        // empty FIFO
        do_reset();
        enable = 1'b1;
        rc = rd_cnt;
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (read_fifo !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("t6_empty", quiet, 1);
        chk("t6_reads", rd_cnt, rc);
        chk("no_underflow", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hit_uart_tx.md
HIT_UART_TX -- requirements
Module: hit_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, SYSCLK cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port SYSCLK  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  permits starting new FIFO reads when high.
REQ-005 SHALL have port fifo_data_available  input  1  hit FIFO non-empty.
REQ-006 SHALL have port fifo_dout  input  8  hit FIFO read data {2'b00, coarse[2:0], fine[2:0]}, valid one cycle after read_fifo.
REQ-007 SHALL have port read_fifo  output  1  single-cycle FIFO read strobe.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port words_sent  output  16  count of completed frames.

Function
REQ-011 SHALL implement states IDLE, READ, LATCH, START, DATA, STOP.
REQ-012 IDLE -> READ when enable=1 and fifo_data_available=1, sampled at the same edge; otherwise remain IDLE.
REQ-013 read_fifo SHALL be high for exactly one cycle, only in READ; never asserted when fifo_data_available=0 at the preceding edge.
REQ-014 READ -> LATCH unconditionally; LATCH captures fifo_dout into an 8-bit shift register, then -> START.
REQ-015 START drives tx=0 for CLKS_PER_BIT cycles, then -> DATA.
REQ-016 DATA shifts 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index; after bit 7 -> STOP.
REQ-017 STOP drives tx=1 for CLKS_PER_BIT cycles, increments words_sent by 1 on its last cycle, then -> IDLE.
REQ-018 tx SHALL be 1 in IDLE, READ, LATCH; it is registered (no combinational glitches).
REQ-019 Baud divider SHALL be a 16-bit down-counter reloaded to CLKS_PER_BIT-1 at each bit boundary; bit period exactly CLKS_PER_BIT cycles, no drift across frames.
REQ-020 Per-word occupancy SHALL be 2 + 10*CLKS_PER_BIT cycles plus 1 IDLE cycle; back-to-back words have no extra gap beyond that IDLE cycle.
REQ-021 enable deasserted mid-frame SHALL NOT abort the frame; block returns to IDLE and starts no new read.
REQ-022 fifo_data_available falling after READ SHALL NOT affect the frame in progress.
REQ-023 words_sent SHALL wrap 0xFFFF -> 0x0000 without saturation.
REQ-024 fifo_dout bits [7:6] SHALL be transmitted as received (no masking).

Reset
REQ-025 RESET high SHALL immediately force state=IDLE, tx=1, read_fifo=0, busy=0, words_sent=0, shift register=0, divider=0, bit index=0.
REQ-026 RESET mid-frame SHALL abandon the frame; the word already read is lost and not counted.
REQ-027 After RESET release, first read SHALL occur no earlier than the second rising SYSCLK edge.

Structure
REQ-028 Shared package SHALL hold the state encoding (3-bit localparams), default CLKS_PER_BIT, and frame length constant (10 bits).
REQ-029 Serializer (START/DATA/STOP, divider, bit index) SHALL be one sub-module uart_tx_core with load/data[7:0]/done handshake; FIFO-read FSM and words_sent stay in hit_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-030 Single word: FIFO holds 0x3A, enable=1 -> one read_fifo pulse; tx = 0,0,1,0,1,1,1,0,0,1 each 4 cycles (40 cycles); words_sent=1; busy low afterwards.
REQ-031 Back-to-back: FIFO holds 0x07, 0x38 -> two read pulses 43 cycles apart; frames decode to 0x07 then 0x38; words_sent=2.
REQ-032 enable gating: enable=0 with FIFO non-empty for 100 cycles -> read_fifo never asserts, tx stays 1; raising enable starts read within 2 cycles.
REQ-033 Mid-frame reset: assert RESET at cycle 15 of frame 0x3F -> tx=1 and busy=0 same cycle; words_sent=0; no further read until RESET released and data available.
REQ-034 Wrap: preload 65535 frames (or force count 0xFFFF), send one word -> words_sent=0x0000.
REQ-035 Empty FIFO: fifo_data_available=0 throughout -> read_fifo never asserted, busy=0, tx=1.
